// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bp_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Widest counter the helpers below can handle.
  localparam int CTR_MAX_W = 16;

  // Saturating step of a w-bit counter: up on taken, down on not-taken.
  function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                    input logic                 taken,
                                                    input int                   w);
    logic [CTR_MAX_W-1:0] max_v;
    logic [CTR_MAX_W-1:0] res;
    if (w >= CTR_MAX_W) max_v = '1;
    else                max_v = (CTR_MAX_W'(1) << w) - CTR_MAX_W'(1);
    res = ctr;
    if (taken) begin
      if (ctr != max_v) res = ctr + CTR_MAX_W'(1);
    end else begin
      if (ctr != '0) res = ctr - CTR_MAX_W'(1);
    end
    return res;
  endfunction

  // Weakly-taken is 100..0, weakly-not-taken is 011..1.
  function automatic logic [CTR_MAX_W-1:0] ctr_init(input logic taken, input int w);
    logic [CTR_MAX_W-1:0] half;
    half = CTR_MAX_W'(1) << (w - 1);
    return taken ? half : (half - CTR_MAX_W'(1));
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: async read port for lookup, sync write port that
// either loads a value (init sweep) or applies a saturating step (update).
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int CTR_W = 2
) (
  input  logic             clk_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_load_i,
  input  logic [CTR_W-1:0] wr_data_i,
  input  logic             wr_taken_i
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] mem_q [DEPTH];
  logic [CTR_W-1:0] wr_cur;
  logic [CTR_W-1:0] wr_ctr_d;

  assign rd_ctr_o = mem_q[rd_idx_i];

  // Value to store: init load, or saturating step of the entry being updated.
  always_comb begin
    wr_cur   = mem_q[wr_idx_i];
    wr_ctr_d = wr_load_i ? wr_data_i
                         : CTR_W'(ctr_next(CTR_MAX_W'(wr_cur), wr_taken_i, CTR_W));
  end

  // Table storage has no reset; the top sweeps it after every reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_ctr_d;
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare predictor top: init sweep FSM, GHR, index hash, mispredict counter.
//
// state | meaning
// INIT  | sweep pointer writes the init counter value, one entry per cycle
// RUN   | table valid; lookups and updates are served
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int IDX_W      = 6,
  parameter int GHR_W      = 4,
  parameter int CTR_W      = 2,
  parameter int INIT_TAKEN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             predict_o,
  output logic [IDX_W-1:0] pred_idx_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_i,
  output logic             ready_o,
  output logic [15:0]      misp_cnt_o
);

  // A zero-length history still needs a one-bit register; it is held at 0.
  localparam int               GHR_EFF  = (GHR_W == 0) ? 1 : GHR_W;
  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init(INIT_TAKEN != 0, CTR_W));
  localparam logic [IDX_W-1:0] PTR_LAST = '1;

  bp_state_e          state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [GHR_EFF-1:0] ghr_q, ghr_d;
  logic [15:0]        misp_q, misp_d;

  logic [GHR_EFF-1:0] ghr_shift;
  logic [IDX_W-1:0]   ghr_ext;
  logic [CTR_W-1:0]   rd_ctr;
  logic               pht_we;
  logic [IDX_W-1:0]   pht_wr_idx;
  logic               pht_wr_load;
  logic               unused_pc;

  generate
    if (GHR_W == 0) begin : g_bimodal
      assign ghr_shift = '0;
      assign ghr_ext   = '0;
    end else if (GHR_EFF == 1) begin : g_ghr1
      assign ghr_shift = upd_taken_i;
      assign ghr_ext   = IDX_W'(ghr_q);
    end else begin : g_ghrn
      assign ghr_shift = {ghr_q[GHR_EFF-2:0], upd_taken_i};
      assign ghr_ext   = IDX_W'(ghr_q);
    end
  endgenerate

  // Only PC bits [IDX_W+1:2] feed the hash.
  assign unused_pc  = ^pred_pc_i;
  assign pred_idx_o = pred_pc_i[IDX_W+1:2] ^ ghr_ext;
  assign ready_o    = (state_q == RUN);
  assign predict_o  = ready_o & pred_valid_i & rd_ctr[CTR_W-1];
  assign misp_cnt_o = misp_q;

  bp_pht #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk_i      (clk_i),
    .rd_idx_i   (pred_idx_o),
    .rd_ctr_o   (rd_ctr),
    .we_i       (pht_we),
    .wr_idx_i   (pht_wr_idx),
    .wr_load_i  (pht_wr_load),
    .wr_data_i  (INIT_VAL),
    .wr_taken_i (upd_taken_i)
  );

  // Next state, and the write-port mux between sweep and resolved updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ghr_d       = ghr_q;
    misp_d      = misp_q;
    pht_we      = 1'b0;
    pht_wr_idx  = upd_idx_i;
    pht_wr_load = 1'b0;
    case (state_q)
      INIT: begin
        pht_we      = 1'b1;
        pht_wr_idx  = ptr_q;
        pht_wr_load = 1'b1;
        ptr_d       = ptr_q + IDX_W'(1);
        if (ptr_q == PTR_LAST) state_d = RUN;
      end
      RUN: begin
        if (upd_valid_i) begin
          pht_we = 1'b1;
          ghr_d  = ghr_shift;
          if ((upd_taken_i != upd_pred_i) && (misp_q != 16'hFFFF))
            misp_d = misp_q + 16'd1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control registers; reset restarts the sweep and drops any same-cycle update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ghr_q   <= '0;
      misp_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
      misp_q  <= misp_d;
    end
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised gshare branch predictor, successor to the single 2-bit-history predictor. It replaces the single counter with a pattern history table (PHT) of saturating counters indexed by PC XOR global history. The table is initialised after reset by a sweep FSM, and the block keeps a saturating mispredict count. It sits between IF, which performs lookup, and EX, which performs resolve/update, in the pipelined CPU.

## Interface
- `PC_W`, 32: width of the fetch PC.
- `IDX_W`, 6: PHT index width; the table has 2^`IDX_W` entries.
- `GHR_W`, 4: global history length. Constraint: 0 ≤ `GHR_W` ≤ `IDX_W`. When `GHR_W` = 0 the block is a bimodal predictor.
- `CTR_W`, 2: counter width. Constraint: `CTR_W` ≥ 1.
- `INIT_TAKEN`, 1: at init, 1 loads weakly-taken (100..0); 0 loads weakly-not-taken (011..1).
- `clk_i`, in, 1: clock. One clock only; everything is on the rising edge.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `pred_valid_i`, in, 1: IF lookup request.
- `pred_pc_i`, in, `PC_W`: fetch PC.
- `predict_o`, out, 1: predicted taken.
- `pred_idx_o`, out, `IDX_W`: PHT index used for this lookup; the pipeline carries it to EX.
- `upd_valid_i`, in, 1: EX resolved a conditional branch.
- `upd_idx_i`, in, `IDX_W`: index returned from `pred_idx_o`.
- `upd_taken_i`, in, 1: actual outcome.
- `upd_pred_i`, in, 1: prediction that was made for this branch.
- `ready_o`, out, 1: table initialised.
- `misp_cnt_o`, out, 16: saturating mispredict count.

## Operation
- **Index:** `pred_idx_o` = `pred_pc_i`[`IDX_W`+1:2] XOR zero-extended `ghr`. The index is combinational.
- **Prediction:** `predict_o` = MSB of PHT[`pred_idx_o`] when `ready_o`=1 and `pred_valid_i`=1, else 0.
- **Update** (`upd_valid_i`=1 and `ready_o`=1):
  - PHT[`upd_idx_i`] increments when `upd_taken_i`=1 and decrements otherwise.
  - The counter saturates at all-ones and at zero.
  - `ghr` becomes {`ghr`[`GHR_W`-2:0], `upd_taken_i`}.
  - `misp_cnt_o` increments when `upd_taken_i` != `upd_pred_i`, saturating at 16'hFFFF.
- **GHR policy:** the GHR is non-speculative; only resolved branches shift it.
- **FSM states:**
  - INIT: a sweep pointer walks 0 → 2^`IDX_W`-1, writing the init value into one entry per cycle. `ready_o`=0 and `upd_valid_i` is ignored. After the last entry is written, the FSM moves to RUN.
  - RUN: `ready_o`=1. The block performs lookups and updates and stays in RUN until `rst_i`.
- **Reset values:**
  - FSM enters INIT with the pointer at 0.
  - `ghr`=0 and `misp_cnt_o`=0.
  - `predict_o`=0 and `ready_o`=0.
  - PHT contents are undefined until the sweep completes.
- **Reset mid-operation:** any cycle with `rst_i`=1 aborts the current state and restarts INIT from pointer 0, including a reset during an unfinished sweep. An update in that cycle is dropped.

## Timing
- **Lookup latency:** 0 cycles. `predict_o` and `pred_idx_o` are combinational from `pred_pc_i` and the current PHT/GHR state.
- **Update visibility:** an update is written at the clock edge and is visible to lookups in the next cycle.
- **Same-cycle lookup and update to the same index:** the lookup returns the pre-update value (read-before-write). The lookup index uses the pre-shift GHR.
- **Init duration:** exactly 2^`IDX_W` cycles after the cycle in which `rst_i` deasserts; `ready_o` rises on the following edge.
- **Update interface:** one update per cycle maximum. There is no back-pressure: the EX side must not present updates when `ready_o`=0, because they are discarded.

## Structure
- **Shared package `bp_pkg`:**
  - state enum {INIT, RUN};
  - counter next-value helper (saturating inc/dec by `CTR_W`);
  - localparam for the init counter value derived from `INIT_TAKEN`.
- **Sub-module `bp_pht`:**
  - 2^`IDX_W` × `CTR_W` register array;
  - one asynchronous read port and one synchronous write port;
  - the write port is shared between the init sweep and updates through a mux owned by the top FSM.
- **Top level:** holds the FSM, sweep pointer, GHR, index XOR and mispredict counter.

## Test plan
- **Init:** assert `rst_i` for 1 cycle with defaults → `ready_o`=0 for 64 cycles, then 1. The first lookup returns `predict_o`=1 (`INIT_TAKEN`=1) for every PC.
- **Saturation:** three not-taken updates to index 5 → the counter goes 2,1,0,0 and the lookup mapping to index 5 predicts 0. Two taken updates then move it to 2 and the prediction returns to 1.
- **GHR indexing:** resolve taken,taken,not,taken → `ghr`=4'b1101. A lookup with PC 0x40 gives `pred_idx_o` = 6'h10 ^ 6'h0D = 6'h1D.
- **Read-before-write:** in the same cycle, update index 3 not-taken from counter 2 and look up index 3 → `predict_o`=1 that cycle and 0 the next cycle.
- **Mispredict counter:** feed 5 updates with `upd_pred_i` != `upd_taken_i` and 3 matching → `misp_cnt_o`=5. Force the count to 16'hFFFF and feed a further mispredict → it holds at 16'hFFFF.
- **Mid-sweep reset:** reset at sweep pointer 30 → the pointer restarts at 0 and `ready_o` rises 64 cycles after deassert. An update presented during INIT has no effect.
